// File: rtl/mode_record_if.sv
// Record-mode capture bus: conditioned-input side and packed song buffer side.
interface mode_record_if #(
  parameter int unsigned SONG_TIME = 64
);
  logic [6:0]             key_in;
  logic [1:0]             octave_in;
  logic                   record_en;
  logic                   clear;
  logic [SONG_TIME*4-1:0] song_packed;
  logic [SONG_TIME*4-1:0] time_packed;
  logic [SONG_TIME*2-1:0] octave_packed;
  logic [7:0]             note_count;
  logic                   recording;
  logic                   full;
  logic [6:0]             led_out;

  modport master (
    output key_in, octave_in, record_en, clear,
    input  song_packed, time_packed, octave_packed, note_count, recording, full, led_out
  );

  modport slave (
    input  key_in, octave_in, record_en, clear,
    output song_packed, time_packed, octave_packed, note_count, recording, full, led_out
  );
endinterface

// File: rtl/mode_record.sv
// Record-mode capture engine: quantises held notes/rests into duration units
// and packs them into the song/time/octave buffer format used by auto-play.
module mode_record #(
  parameter int unsigned SONG_TIME      = 64,
  parameter int unsigned TICKS_PER_UNIT = 25_000_000
) (
  input  logic         clk,
  input  logic         reset,
  mode_record_if.slave bus
);

  localparam int unsigned PTR_W  = (SONG_TIME > 1) ? $clog2(SONG_TIME) : 1;
  localparam int unsigned TICK_W = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam int unsigned SW     = SONG_TIME * 4;
  localparam int unsigned OW     = SONG_TIME * 2;

  localparam logic [PTR_W-1:0]  FULL_AT  = PTR_W'(SONG_TIME - 2);
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICKS_PER_UNIT - 1);
  localparam logic [SW-1:0]     SONG_RST = {SONG_TIME{4'h9}};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    CAPTURE = 3'd2,
    FINISH  = 3'd3,
    DONE    = 3'd4
  } state_e;

  // synchroniser flops
  logic [6:0] key_s1_q, key_s2_q;
  logic [1:0] oct_s1_q, oct_s2_q;
  logic       rec_s1_q, rec_s2_q, rec_prev_q;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [3:0]         cur_note_q, cur_note_d;
  logic [1:0]         cur_oct_q, cur_oct_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [3:0]         units_q, units_d;
  logic [7:0]         note_count_q, note_count_d;
  logic               full_q, full_d;
  logic               recording_q, recording_d;
  logic [6:0]         led_q, led_d;
  logic [SW-1:0]      song_q, song_d;
  logic [SW-1:0]      time_q, time_d;
  logic [OW-1:0]      oct_q, oct_d;

  logic [3:0]  enc_note;
  logic [3:0]  units_inc;
  logic [3:0]  commit_units;
  logic        ev_change;
  logic        do_commit;
  logic        rec_rise;
  int unsigned slot_idx;

  // Two-flop synchronisers for the asynchronous level inputs, plus record edge history
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_s1_q   <= '0;
      key_s2_q   <= '0;
      oct_s1_q   <= '0;
      oct_s2_q   <= '0;
      rec_s1_q   <= 1'b0;
      rec_s2_q   <= 1'b0;
      rec_prev_q <= 1'b0;
    end else begin
      key_s1_q   <= bus.key_in;
      key_s2_q   <= key_s1_q;
      oct_s1_q   <= bus.octave_in;
      oct_s2_q   <= oct_s1_q;
      rec_s1_q   <= bus.record_en;
      rec_s2_q   <= rec_s1_q;
      rec_prev_q <= rec_s2_q;
    end
  end

  // Lowest pressed key wins; no key is a rest
  always_comb begin
    enc_note = 4'd0;
    for (int k = 6; k >= 0; k--) begin
      if (key_s2_q[k]) enc_note = 4'(k + 1);
    end
  end

  // State and buffer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      cur_note_q   <= '0;
      cur_oct_q    <= '0;
      tick_q       <= '0;
      units_q      <= '0;
      note_count_q <= '0;
      full_q       <= 1'b0;
      recording_q  <= 1'b0;
      led_q        <= '0;
      song_q       <= SONG_RST;
      time_q       <= '0;
      oct_q        <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      cur_note_q   <= cur_note_d;
      cur_oct_q    <= cur_oct_d;
      tick_q       <= tick_d;
      units_q      <= units_d;
      note_count_q <= note_count_d;
      full_q       <= full_d;
      recording_q  <= recording_d;
      led_q        <= led_d;
      song_q       <= song_d;
      time_q       <= time_d;
      oct_q        <= oct_d;
    end
  end

  // Next-state, event quantisation and buffer writes
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    cur_note_d   = cur_note_q;
    cur_oct_d    = cur_oct_q;
    tick_d       = tick_q;
    units_d      = units_q;
    note_count_d = note_count_q;
    full_d       = full_q;
    song_d       = song_q;
    time_d       = time_q;
    oct_d        = oct_q;
    do_commit    = 1'b0;
    slot_idx     = 32'(wr_ptr_q);
    rec_rise     = rec_s2_q & ~rec_prev_q;

    // the current cycle also counts towards the event being timed
    units_inc = units_q;
    if (tick_q == TICK_MAX && units_q != 4'd15) units_inc = units_q + 4'd1;
    commit_units = (units_inc == 4'd0) ? 4'd1 : units_inc;

    ev_change = (enc_note != cur_note_q) ||
                ((enc_note != 4'd0) && (oct_s2_q != cur_oct_q));

    case (state_q)
      IDLE, DONE: begin
        if (bus.clear) begin
          song_d       = SONG_RST;
          time_d       = '0;
          oct_d        = '0;
          note_count_d = '0;
          full_d       = 1'b0;
          state_d      = IDLE;
        end
        if ((state_q == IDLE && rec_s2_q) || (state_q == DONE && rec_rise)) begin
          state_d      = ARMED;
          wr_ptr_d     = '0;
          note_count_d = '0;
          full_d       = 1'b0;
        end
      end

      ARMED: begin
        if (!rec_s2_q) begin
          state_d = FINISH;
        end else if (enc_note != 4'd0) begin
          state_d    = CAPTURE;
          cur_note_d = enc_note;
          cur_oct_d  = oct_s2_q;
          tick_d     = '0;
          units_d    = '0;
        end
      end

      CAPTURE: begin
        if (!rec_s2_q) begin
          // stop wins over any simultaneous key change; trailing rest dropped
          do_commit = (cur_note_q != 4'd0);
          state_d   = FINISH;
        end else if (ev_change) begin
          do_commit  = 1'b1;
          cur_note_d = enc_note;
          cur_oct_d  = (enc_note == 4'd0) ? 2'd0 : oct_s2_q;
          tick_d     = '0;
          units_d    = '0;
          if (wr_ptr_q == FULL_AT) state_d = FINISH;
        end else begin
          tick_d  = (tick_q == TICK_MAX) ? '0 : tick_q + TICK_W'(1);
          units_d = units_inc;
        end
      end

      FINISH: begin
        song_d[slot_idx*4 +: 4] = 4'h9;
        time_d[slot_idx*4 +: 4] = 4'h0;
        oct_d[slot_idx*2 +: 2]  = 2'd0;
        state_d                 = DONE;
      end

      default: state_d = IDLE;
    endcase

    if (do_commit) begin
      song_d[slot_idx*4 +: 4] = cur_note_q;
      time_d[slot_idx*4 +: 4] = commit_units;
      oct_d[slot_idx*2 +: 2]  = cur_oct_q;
      wr_ptr_d                = wr_ptr_q + PTR_W'(1);
      note_count_d            = note_count_q + 8'd1;
      if (wr_ptr_q == FULL_AT) full_d = 1'b1;
    end

    recording_d = (state_d == ARMED) || (state_d == CAPTURE);
    led_d       = 7'd0;
    if (state_d == CAPTURE && cur_note_d != 4'd0 && cur_note_d <= 4'd7)
      led_d = 7'(7'd1 << (cur_note_d - 4'd1));
  end

  assign bus.song_packed   = song_q;
  assign bus.time_packed   = time_q;
  assign bus.octave_packed = oct_q;
  assign bus.note_count    = note_count_q;
  assign bus.recording     = recording_q;
  assign bus.full          = full_q;
  assign bus.led_out       = led_q;

endmodule

// File: tb/tb_mode_record.sv
// Directed bench for mode_record with an expected-value scoreboard.
module tb_mode_record;
  localparam int unsigned SONG_TIME = 8;
  localparam int unsigned TPU       = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mode_record_if #(.SONG_TIME(SONG_TIME)) bus ();

  mode_record #(.SONG_TIME(SONG_TIME), .TICKS_PER_UNIT(TPU)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL sb_empty: observed %0h with no expected entry", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic exp_buf(input string p, input logic [31:0] song, input logic [31:0] tim,
                         input logic [31:0] oct, input logic [31:0] cnt,
                         input logic [31:0] full, input logic [31:0] rec);
    push({p, "_song"}, song);
    push({p, "_time"}, tim);
    push({p, "_oct"},  oct);
    push({p, "_cnt"},  cnt);
    push({p, "_full"}, full);
    push({p, "_rec"},  rec);
  endtask

  task automatic chk_buf();
    chk(32'(bus.song_packed));
    chk(32'(bus.time_packed));
    chk(32'(bus.octave_packed));
    chk(32'(bus.note_count));
    chk(32'(bus.full));
    chk(32'(bus.recording));
  endtask

  // bounded wait for recording to drop, then let the terminator land
  task automatic wait_rec_low();
    int n;
    n = 0;
    while (bus.recording !== 1'b0 && n < 50) begin
      cyc(1);
      n++;
    end
    n_checks++;
    assert (bus.recording === 1'b0) else begin
      n_err++;
      $error("FAIL rec_timeout: observed recording=%b expected 0", bus.recording);
    end
    cyc(2);
  endtask

  initial begin
    reset         = 1'b0;
    bus.key_in    = 7'd0;
    bus.octave_in = 2'd1;
    bus.record_en = 1'b0;
    bus.clear     = 1'b0;

    // 1: reset state
    exp_buf("rst", 32'h9999_9999, 32'h0, 32'h0, 32'd0, 32'd0, 32'd0);
    push("rst_led", 32'h0);
    cyc(3);
    chk_buf();
    chk(32'(bus.led_out));
    reset = 1'b1;
    cyc(2);

    // 2: two notes then a trailing rest
    bus.record_en = 1'b1;
    cyc(4);
    bus.key_in = 7'b0000001;
    cyc(12);
    bus.key_in = 7'b0000100;
    push("t2_led", 32'h4);
    cyc(4);
    chk(32'(bus.led_out));
    cyc(4);
    bus.key_in = 7'd0;
    cyc(4);
    exp_buf("t2", 32'h9999_9931, 32'h0000_0023, 32'h5, 32'd2, 32'd0, 32'd0);
    bus.record_en = 1'b0;
    wait_rec_low();
    chk_buf();

    // 3: leading silence, short tap, rest, saturating note
    bus.octave_in = 2'd2;
    bus.record_en = 1'b1;
    push("t3_rec", 32'd1);
    cyc(4);
    chk(32'(bus.recording));
    cyc(20);
    bus.key_in = 7'b0010000;
    cyc(2);
    bus.key_in = 7'd0;
    cyc(8);
    bus.key_in = 7'b0010000;
    cyc(80);
    exp_buf("t3", 32'h9999_9505, 32'h0000_0F21, 32'h22, 32'd3, 32'd0, 32'd0);
    bus.record_en = 1'b0;
    wait_rec_low();
    bus.key_in = 7'd0;
    chk_buf();

    // 4: fill the buffer with seven notes
    bus.octave_in = 2'd1;
    bus.record_en = 1'b1;
    cyc(4);
    for (int k = 0; k < 7; k++) begin
      bus.key_in = 7'(1 << k);
      cyc(4);
    end
    bus.key_in = 7'd0;
    exp_buf("t4", 32'h9765_4321, 32'h0111_1111, 32'h1555, 32'd7, 32'd1, 32'd0);
    wait_rec_low();
    chk_buf();
    bus.key_in    = 7'b1000000;
    bus.octave_in = 2'd3;
    cyc(10);
    bus.key_in = 7'd0;
    cyc(4);
    exp_buf("t4_ign", 32'h9765_4321, 32'h0111_1111, 32'h1555, 32'd7, 32'd1, 32'd0);
    chk_buf();
    bus.record_en = 1'b0;
    cyc(4);

    // 5: clear ignored while recording, reset aborts, clear in DONE
    bus.octave_in = 2'd2;
    bus.record_en = 1'b1;
    cyc(4);
    bus.key_in = 7'b0000100;
    cyc(4);
    bus.key_in = 7'b0100000;
    cyc(4);
    bus.key_in = 7'b0000001;
    cyc(4);
    exp_buf("t5_cap", 32'h9765_4363, 32'h0111_1111, 32'h155A, 32'd2, 32'd0, 32'd1);
    push("t5_led", 32'h1);
    chk_buf();
    chk(32'(bus.led_out));
    bus.clear = 1'b1;
    cyc(1);
    bus.clear = 1'b0;
    cyc(2);
    exp_buf("t5_clr_rec", 32'h9765_4363, 32'h0111_1111, 32'h155A, 32'd2, 32'd0, 32'd1);
    chk_buf();
    reset         = 1'b0;
    bus.record_en = 1'b0;
    bus.key_in    = 7'd0;
    #1;
    exp_buf("t5_rst", 32'h9999_9999, 32'h0, 32'h0, 32'd0, 32'd0, 32'd0);
    chk_buf();
    cyc(2);
    reset = 1'b1;
    cyc(2);
    bus.record_en = 1'b1;
    cyc(4);
    bus.key_in = 7'b0001000;
    cyc(8);
    exp_buf("t5_done", 32'h9999_9994, 32'h2, 32'h2, 32'd1, 32'd0, 32'd0);
    bus.record_en = 1'b0;
    wait_rec_low();
    bus.key_in = 7'd0;
    chk_buf();
    bus.clear = 1'b1;
    cyc(1);
    bus.clear = 1'b0;
    cyc(1);
    exp_buf("t5_clr_done", 32'h9999_9999, 32'h0, 32'h0, 32'd0, 32'd0, 32'd0);
    chk_buf();

    // 6: octave change mid-note, then stop together with a key change
    bus.octave_in = 2'd1;
    bus.record_en = 1'b1;
    cyc(4);
    bus.key_in = 7'b0000010;
    cyc(8);
    bus.octave_in = 2'd2;
    push("t6_led", 32'h2);
    cyc(4);
    chk(32'(bus.led_out));
    bus.key_in    = 7'b1000000;
    bus.record_en = 1'b0;
    exp_buf("t6", 32'h9999_9922, 32'h12, 32'h9, 32'd2, 32'd0, 32'd0);
    wait_rec_low();
    bus.key_in = 7'd0;
    chk_buf();

    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: observed %0d pending entries expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mode_record.md
Name: mode_record

Overview:
- Record-mode capture engine, the writer-side counterpart to the auto-play path.
- Samples the 7 note keys and octave switches while recording is enabled. Quantises each held note or rest into duration units.
- Packs events into the same packed song/time/octave buffer format the auto-play path consumes: 4-bit note, 4-bit duration, 2-bit octave per slot, terminated by the end marker 9.
- Sits beside the free-play mode; its buffer feeds the song library as a user song slot.

Parameters:
- SONG_TIME, 64, number of slots in the buffer, including the terminator slot.
- TICKS_PER_UNIT, 25_000_000, clk cycles per duration unit.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- key_in  in  7  note keys, bit k = note k+1; asynchronous, level
- octave_in  in  2  octave switches; asynchronous, level
- record_en  in  1  high = record; falling edge = stop
- clear  in  1  one-cycle synchronous buffer clear; honoured only in IDLE/DONE
- song_packed  out  SONG_TIME*4  note per slot; slot i at [4i+3:4i]
- time_packed  out  SONG_TIME*4  duration units per slot, 1..15
- octave_packed  out  SONG_TIME*2  octave per slot
- note_count  out  8  committed events, excluding the terminator
- recording  out  1  high in ARMED/CAPTURE
- full  out  1  buffer exhausted
- led_out  out  7  one-hot of the current note; 0 for rest

Behaviour:
- Reset (async, reset=0):
  - all song slots = 9, all time slots = 0, all octave slots = 0;
  - note_count=0, full=0, recording=0, led_out=0;
  - state IDLE, synchronisers cleared.
- Input conditioning:
  - key_in, octave_in and record_en pass through 2-FF synchronisers, giving 2-cycle latency.
  - Note encode: lowest set key bit k gives note k+1; no key gives rest 0.
- FSM states: IDLE, ARMED, CAPTURE, FINISH, DONE.
- IDLE:
  - sync record_en=1 → ARMED; wr_ptr=0; note_count=0; full=0.
  - clear → all slots back to reset values, note_count=0.
- ARMED:
  - Leading silence is not recorded.
  - First non-rest encoded note → CAPTURE: cur_note/cur_oct latched, tick_cnt=0, units=0.
  - record_en=0 → FINISH.
- CAPTURE:
  - tick_cnt counts to TICKS_PER_UNIT-1, then wraps and increments units; units saturates at 15.
  - Event change is a new encoded note ≠ cur_note, or a new octave ≠ cur_oct while the note is non-rest.
  - On an event change, in the same cycle:
    - slot[wr_ptr] ← {cur_note, max(1,units), cur_oct};
    - wr_ptr++ and note_count++;
    - the new event is latched with tick_cnt=0, units=0.
  - Rests between notes are events with note 0 and octave 0.
  - After a commit that makes wr_ptr = SONG_TIME-1 → FINISH, with full=1 from that cycle; further key activity is ignored.
  - record_en=0 → FINISH. If cur_note ≠ 0, the current event is committed first, in the same cycle, if room remains. A trailing rest is discarded.
- FINISH:
  - Single cycle.
  - slot[wr_ptr].song ← 9, time ← 0, octave ← 0.
  - → DONE.
- DONE:
  - Buffer is static.
  - clear → IDLE behaviour.
  - Rising sync record_en → ARMED. This overwrites from slot 0; full and note_count are reset.
- Simultaneous events:
  - Stop and key change in the same cycle: stop wins. The old event is committed; the new note is not recorded.
  - clear while recording has no effect.
- Reset mid-recording aborts immediately; the buffer returns to all-9.
- led_out tracks cur_note in CAPTURE and is 0 otherwise.
- Outputs are registered; packed buffers update 1 cycle after the triggering synchronised input.

Test Plan (SONG_TIME=8, TICKS_PER_UNIT=4):
1. Reset, then read outputs → all song nibbles = 9, time=0, octave=0, note_count=0, full=0, led_out=0.
2. Arm; key_in bit0 held 12 cycles; key bit2 held 8 cycles; release all; stop.
   - Required: slot0={1,3,oct}, slot1={3,2,oct}, slot2.song=9, note_count=2.
   - The trailing rest is not stored.
3. Arm; idle 20 cycles; tap key bit4 for 2 cycles; silence 8 cycles; key bit4 held 80 cycles; stop.
   - Leading silence ignored; slot0={5,1}, slot1={0,2}, slot2={5,15} (saturated), slot3=9.
4. Arm; play 7 distinct notes back-to-back.
   - Required: full=1 after the 7th commit, slot7.song=9, note_count=7.
   - Further keys do not change the buffer.
5. Assert reset during CAPTURE after 2 commits → buffer all-9 immediately.
   - Pulse clear while recording → no effect.
   - Pulse clear in DONE → buffer reset.
6. Hold key bit1 and change octave_in 1→2 mid-note → two events {2,x,1},{2,y,2}.
   - Stop in the same cycle as a key change → only the old event is stored.
